// File: rtl/xor_lrc_unit_if.sv
// Word-stream in / frame-result out handshake bundle for the LRC unit.
// master drives the word stream and result acceptance; slave is the LRC unit.
interface xor_lrc_unit_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_lrc;
  logic             out_bit;
  logic             out_err;
  logic [CNT_W-1:0] out_count;

  modport master (
    output in_valid, in_data, in_last, mode, out_ready,
    input  in_ready, out_valid, out_lrc, out_bit, out_err, out_count
  );

  modport slave (
    input  in_valid, in_data, in_last, mode, out_ready,
    output in_ready, out_valid, out_lrc, out_bit, out_err, out_count
  );
endinterface

// File: rtl/xor_lrc_unit.sv
// Streaming column-wise XOR (LRC) over a frame of words, with generate and check modes.
// Results are held in registers until the downstream accepts them.
module xor_lrc_unit #(
  parameter int WIDTH = 8,
  parameter bit ODD   = 1'b0,
  parameter int CNT_W = 8
) (
  input logic           clk,
  input logic           rst,
  xor_lrc_unit_if.slave bus
);
  typedef enum logic {ACCUM, HOLD} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [WIDTH-1:0] CHECK_OK = ODD ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic             mode_q;
  logic             mode_eff;
  logic             vld_r;
  logic [WIDTH-1:0] lrc_r;
  logic             bit_r;
  logic             err_r;
  logic [CNT_W-1:0] cnt_r;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

  function automatic logic [WIDTH-1:0] apply_sense(input logic [WIDTH-1:0] r);
    return ODD ? ~r : r;
  endfunction

  function automatic logic reduce_bit(input logic [WIDTH-1:0] r);
    return ODD ? ~^r : ^r;
  endfunction

  // The first beat of a frame uses the live mode; later beats use the latched copy.
  always_comb begin
    acc_nxt   = acc ^ bus.in_data;
    count_nxt = sat_inc(count);
    mode_eff  = (count == '0) ? bus.mode : mode_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ACCUM;
      acc    <= '0;
      count  <= '0;
      mode_q <= 1'b0;
      vld_r  <= 1'b0;
      lrc_r  <= '0;
      bit_r  <= 1'b0;
      err_r  <= 1'b0;
      cnt_r  <= '0;
    end else begin
      case (state)
        ACCUM: begin
          if (bus.in_valid) begin
            acc   <= acc_nxt;
            count <= count_nxt;
            if (count == '0) mode_q <= bus.mode;
            if (bus.in_last) begin
              lrc_r <= apply_sense(acc_nxt);
              bit_r <= reduce_bit(acc_nxt);
              err_r <= mode_eff && (acc_nxt != CHECK_OK);
              cnt_r <= count_nxt;
              vld_r <= 1'b1;
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            acc   <= '0;
            count <= '0;
            vld_r <= 1'b0;
            state <= ACCUM;
          end
        end
      endcase
    end
  end

  assign bus.in_ready  = (state == ACCUM);
  assign bus.out_valid = vld_r;
  assign bus.out_lrc   = lrc_r;
  assign bus.out_bit   = bit_r;
  assign bus.out_err   = err_r;
  assign bus.out_count = cnt_r;
endmodule

// File: tb/tb_xor_lrc_unit.sv
// Drives an even/8-bit-count unit and an odd/3-bit-count unit with the same word stream
// and compares both against a frame-level LRC model.
module tb_xor_lrc_unit;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_last = 1'b0;
  logic       mode = 1'b0;
  logic       out_ready = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] acc_q[$];
  logic       first_mode;
  logic [7:0] e_lrc0, e_lrc1;
  logic       e_bit0, e_bit1, e_err0, e_err1;
  int         e_cnt0, e_cnt1;

  always #5 clk = ~clk;

  xor_lrc_unit_if #(.WIDTH(8), .CNT_W(8)) if0 ();
  xor_lrc_unit_if #(.WIDTH(8), .CNT_W(3)) if1 ();

  assign if0.in_valid = in_valid;  assign if1.in_valid = in_valid;
  assign if0.in_data  = in_data;   assign if1.in_data  = in_data;
  assign if0.in_last  = in_last;   assign if1.in_last  = in_last;
  assign if0.mode     = mode;      assign if1.mode     = mode;
  assign if0.out_ready = out_ready; assign if1.out_ready = out_ready;

  xor_lrc_unit #(.WIDTH(8), .ODD(1'b0), .CNT_W(8)) dut_even (.clk(clk), .rst(rst), .bus(if0));
  xor_lrc_unit #(.WIDTH(8), .ODD(1'b1), .CNT_W(3)) dut_odd  (.clk(clk), .rst(rst), .bus(if1));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called on a falling edge; returns on the falling edge after the beat is taken.
  task automatic send_beat(input logic [7:0] d, input logic l, input logic m);
    int n = 0;
    in_valid = 1'b1; in_data = d; in_last = l; mode = m;
    while (!if0.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("ready_timeout", 32'(if0.in_ready), 32'd1);
    @(posedge clk);
    if (acc_q.size() == 0) first_mode = m;
    acc_q.push_back(d);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic close_frame();
    logic [7:0] r = '0;
    foreach (acc_q[i]) r ^= acc_q[i];
    e_lrc0 = r;   e_bit0 = ^r;   e_err0 = first_mode && (r != 8'h00);
    e_lrc1 = ~r;  e_bit1 = ~^r;  e_err1 = first_mode && (r != 8'hFF);
    e_cnt0 = (acc_q.size() > 255) ? 255 : acc_q.size();
    e_cnt1 = (acc_q.size() > 7)   ? 7   : acc_q.size();
    acc_q.delete();
  endtask

  task automatic check_out(input string tag);
    chk({tag, ".vld0"}, 32'(if0.out_valid), 32'd1);
    chk({tag, ".vld1"}, 32'(if1.out_valid), 32'd1);
    chk({tag, ".rdy0"}, 32'(if0.in_ready), 32'd0);
    chk({tag, ".lrc0"}, 32'(if0.out_lrc), 32'(e_lrc0));
    chk({tag, ".bit0"}, 32'(if0.out_bit), 32'(e_bit0));
    chk({tag, ".err0"}, 32'(if0.out_err), 32'(e_err0));
    chk({tag, ".cnt0"}, 32'(if0.out_count), 32'(e_cnt0));
    chk({tag, ".lrc1"}, 32'(if1.out_lrc), 32'(e_lrc1));
    chk({tag, ".bit1"}, 32'(if1.out_bit), 32'(e_bit1));
    chk({tag, ".err1"}, 32'(if1.out_err), 32'(e_err1));
    chk({tag, ".cnt1"}, 32'(if1.out_count), 32'(e_cnt1));
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("rel.vld0", 32'(if0.out_valid), 32'd0);
    chk("rel.vld1", 32'(if1.out_valid), 32'd0);
    chk("rel.rdy0", 32'(if0.in_ready), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d, x, lastw;
    int len, kind;
    logic fm, m;

    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst.vld", 32'(if0.out_valid), 32'd0);
    chk("rst.lrc", 32'(if0.out_lrc), 32'd0);
    chk("rst.err", 32'(if0.out_err), 32'd0);
    chk("rst.cnt", 32'(if0.out_count), 32'd0);
    chk("rst.rdy", 32'(if0.in_ready), 32'd1);
    chk("rst.lrc1", 32'(if1.out_lrc), 32'd0);

    // Generate, even
    send_beat(8'h0F, 1'b0, 1'b0);
    send_beat(8'hF0, 1'b0, 1'b0);
    send_beat(8'h3C, 1'b1, 1'b0);
    close_frame();
    check_out("gen");
    chk("gen.lrc_c", 32'(if0.out_lrc), 32'hC3);
    chk("gen.bit_c", 32'(if0.out_bit), 32'd0);
    chk("gen.cnt_c", 32'(if0.out_count), 32'd3);
    chk("gen.err_c", 32'(if0.out_err), 32'd0);
    release_out();

    // Check, even: good and bad transmitted LRC
    send_beat(8'h0F, 1'b0, 1'b1);
    send_beat(8'hF0, 1'b0, 1'b1);
    send_beat(8'h3C, 1'b0, 1'b1);
    send_beat(8'hC3, 1'b1, 1'b1);
    close_frame();
    check_out("chk_ok");
    chk("chk_ok.err_c", 32'(if0.out_err), 32'd0);
    chk("chk_ok.cnt_c", 32'(if0.out_count), 32'd4);
    release_out();
    send_beat(8'h0F, 1'b0, 1'b1);
    send_beat(8'hF0, 1'b0, 1'b1);
    send_beat(8'h3C, 1'b0, 1'b1);
    send_beat(8'hC2, 1'b1, 1'b1);
    close_frame();
    check_out("chk_bad");
    chk("chk_bad.err_c", 32'(if0.out_err), 32'd1);
    chk("chk_bad.lrc_c", 32'(if0.out_lrc), 32'h01);
    chk("chk_bad.bit_c", 32'(if0.out_bit), 32'd1);
    release_out();

    // Backpressure with a held beat waiting
    send_beat(8'h5A, 1'b0, 1'b0);
    send_beat(8'h66, 1'b1, 1'b0);
    close_frame();
    in_valid = 1'b1; in_data = 8'h11; in_last = 1'b0; mode = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check_out("bp");
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp.rel_vld", 32'(if0.out_valid), 32'd0);
    chk("bp.rel_rdy", 32'(if0.in_ready), 32'd1);
    send_beat(8'h11, 1'b0, 1'b0);
    send_beat(8'h22, 1'b1, 1'b0);
    close_frame();
    check_out("bp2");
    chk("bp2.lrc_c", 32'(if0.out_lrc), 32'h33);
    chk("bp2.cnt_c", 32'(if0.out_count), 32'd2);
    release_out();

    // Odd sense
    send_beat(8'hA5, 1'b1, 1'b0);
    close_frame();
    check_out("odd1");
    chk("odd1.lrc_c", 32'(if1.out_lrc), 32'h5A);
    chk("odd1.bit_c", 32'(if1.out_bit), 32'd1);
    chk("odd1.cnt_c", 32'(if1.out_count), 32'd1);
    release_out();
    send_beat(8'hA5, 1'b0, 1'b1);
    send_beat(8'h5A, 1'b1, 1'b1);
    close_frame();
    check_out("odd2");
    chk("odd2.err_c", 32'(if1.out_err), 32'd0);
    release_out();

    // Reset mid-frame
    send_beat(8'hFF, 1'b0, 1'b1);
    send_beat(8'h01, 1'b0, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    acc_q.delete();
    chk("mrst.vld", 32'(if0.out_valid), 32'd0);
    chk("mrst.rdy", 32'(if0.in_ready), 32'd1);
    chk("mrst.cnt", 32'(if0.out_count), 32'd0);
    send_beat(8'h01, 1'b1, 1'b0);
    close_frame();
    check_out("mrst2");
    chk("mrst2.lrc_c", 32'(if0.out_lrc), 32'h01);
    chk("mrst2.cnt_c", 32'(if0.out_count), 32'd1);
    release_out();

    // Mode toggled mid-frame stays in generate
    send_beat(8'h12, 1'b0, 1'b0);
    send_beat(8'h34, 1'b0, 1'b1);
    send_beat(8'h56, 1'b1, 1'b1);
    close_frame();
    check_out("mchg");
    chk("mchg.err_c", 32'(if0.out_err), 32'd0);
    release_out();

    // Count saturation on the 3-bit counter
    for (int i = 0; i < 10; i++) send_beat(8'($urandom), (i == 9), 1'b0);
    close_frame();
    check_out("sat");
    chk("sat.cnt1_c", 32'(if1.out_count), 32'd7);
    chk("sat.cnt0_c", 32'(if0.out_count), 32'd10);
    release_out();

    // Randomized frames
    for (int f = 0; f < 40; f++) begin
      len  = $urandom_range(1, 12);
      kind = $urandom_range(0, 2);
      fm   = 1'($urandom_range(0, 1));
      x    = '0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      for (int i = 0; i < len - 1; i++) begin
        d = 8'($urandom);
        x ^= d;
        m = (i == 0) ? fm : 1'($urandom_range(0, 1));
        send_beat(d, 1'b0, m);
      end
      case (kind)
        0:       lastw = x;
        1:       lastw = ~x;
        default: lastw = 8'($urandom);
      endcase
      m = (len == 1) ? fm : 1'($urandom_range(0, 1));
      send_beat(lastw, 1'b1, m);
      close_frame();
      check_out("rnd");
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        check_out("rnd.hold");
      end
      release_out();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
